jelly_fifo_ra_read_window: RTL and testbench

//  Address generator feeding jelly_fifo_ra_read_fwtf (s_user/s_addr/s_valid/s_ready) on a random-access FIFO.

---
 rtl/jelly_fifo_ra_read_window_if.sv | 41 ++++
 rtl/jelly_fifo_ra_read_window.sv | 163 ++++++++++++++++
 tb/tb_jelly_fifo_ra_read_window.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jelly_fifo_ra_read_window_if.sv
// Bus bundle between the read-window address generator and its surroundings:
// command channel, FIFO occupancy/release, and the address stream towards read_fwtf.
// The window block uses "master" (it masters the address stream and the release
// request); the command source, FIFO and read_fwtf side together use "slave".
interface jelly_fifo_ra_read_window_if #(
  parameter int USER_WIDTH = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int PTR_WIDTH  = ADDR_WIDTH + 1
);
  logic [USER_WIDTH-1:0] cmd_user;
  logic [PTR_WIDTH-1:0]  cmd_offset;
  logic [PTR_WIDTH-1:0]  cmd_len;
  logic                  cmd_release;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_error;

  logic [PTR_WIDTH-1:0]  rd_count;
  logic                  rd_release_en;
  logic [PTR_WIDTH-1:0]  rd_release_size;

  logic [USER_WIDTH-1:0] m_user;
  logic                  m_last;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  cmd_user, cmd_offset, cmd_len, cmd_release, cmd_valid,
    input  rd_count, m_ready,
    output cmd_ready, cmd_error, rd_release_en, rd_release_size,
    output m_user, m_last, m_addr, m_valid
  );

  modport slave (
    output cmd_user, cmd_offset, cmd_len, cmd_release, cmd_valid,
    output rd_count, m_ready,
    input  cmd_ready, cmd_error, rd_release_en, rd_release_size,
    input  m_user, m_last, m_addr, m_valid
  );
endinterface

// File: rtl/jelly_fifo_ra_read_window.sv
// Read-window address generator for a random-access FIFO.
// Takes (offset, length) commands relative to the FIFO head, waits until the
// FIFO holds offset+length entries, streams absolute RAM addresses
// head+offset+i, and optionally pops offset+length entries afterwards.
// A private head pointer is advanced by every release this block issues.
module jelly_fifo_ra_read_window #(
  parameter int USER_WIDTH = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int PTR_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                               clk,
  input  logic                               reset,
  jelly_fifo_ra_read_window_if.master        bus
);

  localparam logic [PTR_WIDTH:0]    DEPTH    = (PTR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [PTR_WIDTH-1:0]  PTR_ONE  = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0]  PTR_TWO  = PTR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RUN,
    ST_RELEASE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] head;
  logic [PTR_WIDTH-1:0]  remaining;
  logic                  cur_release;

  // Command payload, latched on acceptance; only meaningful after CHECK is entered.
  logic [USER_WIDTH-1:0] cur_user;
  logic [ADDR_WIDTH-1:0] cur_offset;
  logic [PTR_WIDTH:0]    need;

  logic                  cmd_ready;
  logic                  cmd_error;
  logic                  rd_release_en;
  logic [PTR_WIDTH-1:0]  rd_release_size;
  logic [USER_WIDTH-1:0] m_user;
  logic                  m_last;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic                  m_valid;

  // One extra bit so offset+len can never wrap before the depth comparison.
  logic [PTR_WIDTH:0]    need_in;
  logic                  count_ok;
  logic [ADDR_WIDTH-1:0] start_addr;

  assign need_in    = {1'b0, bus.cmd_offset} + {1'b0, bus.cmd_len};
  assign count_ok   = ({1'b0, bus.rd_count} >= need);
  assign start_addr = head + cur_offset;

  assign bus.cmd_ready       = cmd_ready;
  assign bus.cmd_error       = cmd_error;
  assign bus.rd_release_en   = rd_release_en;
  assign bus.rd_release_size = rd_release_size;
  assign bus.m_user          = m_user;
  assign bus.m_last          = m_last;
  assign bus.m_addr          = m_addr;
  assign bus.m_valid         = m_valid;

  // Capture the command payload whenever the block is ready to accept one.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.cmd_valid) begin
      cur_user   <= bus.cmd_user;
      cur_offset <= bus.cmd_offset[ADDR_WIDTH-1:0];
      need       <= need_in;
    end
  end

  // Command FSM: accept/validate, wait for occupancy, stream beats, optional release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      head            <= '0;
      remaining       <= '0;
      cur_release     <= 1'b0;
      cmd_ready       <= 1'b1;
      cmd_error       <= 1'b0;
      rd_release_en   <= 1'b0;
      rd_release_size <= '0;
      m_user          <= '0;
      m_last          <= 1'b0;
      m_addr          <= '0;
      m_valid         <= 1'b0;
    end else begin
      cmd_error     <= 1'b0;
      rd_release_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            if (need_in > DEPTH) begin
              cmd_error <= 1'b1;
            end else begin
              remaining   <= bus.cmd_len;
              cur_release <= bus.cmd_release;
              cmd_ready   <= 1'b0;
              state       <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (count_ok) begin
            if (remaining != '0) begin
              m_valid <= 1'b1;
              m_addr  <= start_addr;
              m_user  <= cur_user;
              m_last  <= (remaining == PTR_ONE);
              state   <= ST_RUN;
            end else if (cur_release) begin
              rd_release_en   <= 1'b1;
              rd_release_size <= need[PTR_WIDTH-1:0];
              head            <= head + need[ADDR_WIDTH-1:0];
              state           <= ST_RELEASE;
            end else begin
              cmd_ready <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end

        ST_RUN: begin
          if (bus.m_ready) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              if (cur_release) begin
                rd_release_en   <= 1'b1;
                rd_release_size <= need[PTR_WIDTH-1:0];
                head            <= head + need[ADDR_WIDTH-1:0];
                state           <= ST_RELEASE;
              end else begin
                cmd_ready <= 1'b1;
                state     <= ST_IDLE;
              end
            end else begin
              m_addr    <= m_addr + ADDR_ONE;
              remaining <= remaining - PTR_ONE;
              m_last    <= (remaining == PTR_TWO);
            end
          end
        end

        // The FIFO count reflects the pop one cycle after the pulse, so pass
        // through IDLE before any new CHECK looks at it.
        ST_RELEASE: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jelly_fifo_ra_read_window.sv
// Self-checking bench for jelly_fifo_ra_read_window (depth 8 instance).
// Reference model: a head pointer plus the rule "beat i of a command carries
// address (head+offset+i) mod depth"; releases advance head by offset+len.
module tb_jelly_fifo_ra_read_window;

  localparam int USER_WIDTH = 4;
  localparam int ADDR_WIDTH = 3;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
  localparam int DEPTH      = 2**ADDR_WIDTH;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  jelly_fifo_ra_read_window_if #(
    .USER_WIDTH(USER_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .PTR_WIDTH(PTR_WIDTH)
  ) bus ();

  jelly_fifo_ra_read_window #(
    .USER_WIDTH(USER_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .PTR_WIDTH(PTR_WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int mdl_head = 0;

  task automatic apply_reset();
    reset           = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_user    = '0;
    bus.cmd_offset  = '0;
    bus.cmd_len     = '0;
    bus.cmd_release = 1'b0;
    bus.rd_count    = '0;
    bus.m_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    mdl_head = 0;
  endtask

  // Issue one command and follow it to completion, checking every beat, the
  // release pulse and the return to idle against the model.
  // rmode: 0 = m_ready always 1, 1 = pattern 1,0,0 repeating, 2 = random.
  task automatic do_cmd(input int off, input int len, input bit rel, input int user,
                        input int cnt0, input int cnt1, input int dly, input int rmode,
                        input string tag);
    int need;
    int idx;
    int cyc;
    int stall_ph;
    bit rel_seen;
    bit done;
    bit gate_seen;
    logic [ADDR_WIDTH-1:0] exp_addr;
    need = off + len;

    cyc = 0;
    while (bus.cmd_ready !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_ready: got %b want 1", tag, bus.cmd_ready);
    end

    bus.rd_count    = PTR_WIDTH'(cnt0);
    bus.cmd_offset  = PTR_WIDTH'(off);
    bus.cmd_len     = PTR_WIDTH'(len);
    bus.cmd_release = rel;
    bus.cmd_user    = USER_WIDTH'(user);
    bus.cmd_valid   = 1'b1;
    bus.m_ready     = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid   = 1'b0;

    if (need > DEPTH) begin
      n_cmp++;
      if (bus.cmd_error !== 1'b1 || bus.cmd_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s error_pulse: err=%b rdy=%b vld=%b want 1 1 0",
                 tag, bus.cmd_error, bus.cmd_ready, bus.m_valid);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.cmd_error !== 1'b0 || bus.rd_release_en !== 1'b0) begin
        n_fail++;
        $display("FAIL %s error_width: err=%b rel=%b want 0 0",
                 tag, bus.cmd_error, bus.rd_release_en);
      end
      return;
    end

    n_cmp++;
    if (bus.cmd_error !== 1'b0 || bus.m_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: err=%b vld=%b rdy=%b want 0 0 0",
               tag, bus.cmd_error, bus.m_valid, bus.cmd_ready);
    end

    idx = 0; rel_seen = 1'b0; done = 1'b0; gate_seen = 1'b0; stall_ph = 0;
    for (cyc = 0; cyc < 300 && !done; cyc++) begin
      if (cyc == dly && !rel_seen) bus.rd_count = PTR_WIDTH'(cnt1);
      gate_seen = gate_seen | (int'(bus.rd_count) >= need);
      case (rmode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = (stall_ph % 3 == 0);
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
      stall_ph++;
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) idx++;
      @(posedge clk); #1;

      if (bus.m_valid === 1'b1) begin
        exp_addr = ADDR_WIDTH'((mdl_head + off + idx) % DEPTH);
        n_cmp++;
        if (!gate_seen || idx >= len || bus.m_addr !== exp_addr ||
            bus.m_last !== (idx == len - 1) || bus.m_user !== USER_WIDTH'(user)) begin
          n_fail++;
          $display("FAIL %s beat%0d: addr=%0d last=%b user=%0d gate=%b want addr=%0d last=%b user=%0d (len %0d)",
                   tag, idx, bus.m_addr, bus.m_last, bus.m_user, gate_seen,
                   exp_addr, (idx == len - 1), user, len);
        end
      end

      if (bus.rd_release_en === 1'b1) begin
        n_cmp++;
        if (!(rel && idx == len && !rel_seen) || bus.rd_release_size !== PTR_WIDTH'(need)) begin
          n_fail++;
          $display("FAIL %s release: size=%0d beats_done=%0d want size=%0d rel=%b beats=%0d",
                   tag, bus.rd_release_size, idx, need, rel, len);
        end
        rel_seen     = 1'b1;
        mdl_head     = (mdl_head + need) % DEPTH;
        bus.rd_count = PTR_WIDTH'(int'(bus.rd_count) - need);
      end

      if (bus.cmd_ready === 1'b1) begin
        done = 1'b1;
        n_cmp++;
        if (idx != len || rel_seen != rel || bus.m_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s done: beats=%0d released=%b vld=%b want beats=%0d released=%b vld=0",
                   tag, idx, rel_seen, bus.m_valid, len, rel);
        end
      end
    end

    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: beats=%0d want %0d, cmd_ready never returned", tag, idx, len);
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (bus.cmd_ready !== 1'b1 || bus.cmd_error !== 1'b0 || bus.m_valid !== 1'b0 ||
        bus.m_last !== 1'b0 || bus.m_addr !== '0 || bus.m_user !== '0 ||
        bus.rd_release_en !== 1'b0 || bus.rd_release_size !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b err=%b vld=%b last=%b addr=%0d user=%0d rel=%b size=%0d want 1 0 0 0 0 0 0 0",
               bus.cmd_ready, bus.cmd_error, bus.m_valid, bus.m_last, bus.m_addr,
               bus.m_user, bus.rd_release_en, bus.rd_release_size);
    end
  endtask

  task automatic test_basic();
    do_cmd(2, 3, 1'b0, 10, 8, 8, 0, 0, "basic");
    do_cmd(0, 1, 1'b0, 3, 8, 8, 0, 0, "basic_head");
  endtask

  task automatic test_wait_release();
    do_cmd(0, 4, 1'b1, 5, 2, 4, 5, 0, "wait_rel");
    do_cmd(0, 2, 1'b0, 6, 8, 8, 0, 0, "after_rel");
  endtask

  task automatic test_wrap();
    do_cmd(0, 2, 1'b1, 1, 8, 8, 0, 0, "wrap_prep");
    do_cmd(1, 4, 1'b1, 7, 5, 5, 0, 0, "wrap");
    do_cmd(0, 1, 1'b0, 2, 8, 8, 0, 0, "wrap_head");
  endtask

  task automatic test_stall();
    do_cmd(1, 6, 1'b0, 9, 8, 8, 0, 1, "stall_pat");
    do_cmd(0, 5, 1'b1, 12, 8, 8, 0, 2, "stall_rand");
  endtask

  task automatic test_zero_len();
    do_cmd(3, 0, 1'b1, 4, 3, 3, 0, 0, "zero_rel");
    do_cmd(2, 0, 1'b0, 4, 8, 8, 0, 0, "zero_norel");
    do_cmd(0, 1, 1'b0, 4, 8, 8, 0, 0, "zero_after");
  endtask

  task automatic test_error();
    do_cmd(6, 5, 1'b1, 1, 8, 8, 0, 0, "err_6_5");
    do_cmd(8, 1, 1'b0, 1, 8, 8, 0, 0, "err_8_1");
    do_cmd(15, 15, 1'b1, 1, 8, 8, 0, 0, "err_max");
    do_cmd(1, 2, 1'b0, 11, 8, 8, 0, 0, "err_after");
  endtask

  task automatic test_full_window();
    do_cmd(4, 4, 1'b1, 13, 7, 8, 3, 2, "full_rel");
    do_cmd(0, 8, 1'b0, 14, 8, 8, 0, 0, "full_all");
  endtask

  task automatic test_back_to_back();
    int off, len, cnt0, cnt1;
    for (int i = 0; i < 30; i++) begin
      off  = int'($urandom_range(0, 8));
      len  = int'($urandom_range(0, 8));
      cnt0 = int'($urandom_range(0, 8));
      cnt1 = (cnt0 >= off + len || off + len > DEPTH) ? cnt0
             : int'($urandom_range(off + len, 8));
      do_cmd(off, len, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
             cnt0, cnt1, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), "random");
    end
  endtask

  task automatic test_reset_mid_run();
    int hs;
    int cyc;
    bit rel_any;
    apply_reset();
    do_cmd(0, 2, 1'b1, 3, 8, 8, 0, 0, "mid_prep");
    bus.rd_count    = PTR_WIDTH'(8);
    bus.cmd_offset  = PTR_WIDTH'(0);
    bus.cmd_len     = PTR_WIDTH'(5);
    bus.cmd_release = 1'b1;
    bus.cmd_user    = USER_WIDTH'(5);
    bus.cmd_valid   = 1'b1;
    bus.m_ready     = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 2 && cyc < 20) begin
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) hs++;
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (hs != 2 || bus.m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_run_beats: handshakes=%0d vld=%b want 2 1", hs, bus.m_valid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    mdl_head = 0;
    n_cmp++;
    if (bus.m_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rd_release_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_run_reset: vld=%b rdy=%b rel=%b want 0 1 0",
               bus.m_valid, bus.cmd_ready, bus.rd_release_en);
    end
    rel_any = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.rd_release_en === 1'b1 || bus.m_valid === 1'b1) rel_any = 1'b1;
    end
    n_cmp++;
    if (rel_any) begin
      n_fail++;
      $display("FAIL mid_run_quiet: release or beat seen after reset, want none");
    end
    bus.m_ready = 1'b0;
    do_cmd(0, 1, 1'b0, 6, 8, 8, 0, 0, "mid_run_head");
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_basic();
    test_wait_release();
    test_wrap();
    test_stall();
    test_zero_len();
    test_error();
    test_full_window();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
